// File: rtl/satd_ctrl_gen.sv
// Phase sequencer for the SATD datapath: LOAD, HORIZ, VERT and ACC stages with
// an in-stage counter, start/busy/done handshake, stall, chaining and a pass counter.
module satd_ctrl_gen #(
  parameter int N    = 8,
  parameter int CW   = $clog2(N),
  parameter int TAIL = 2,
  parameter int BW   = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stall,
  input  logic          continuous,
  output logic [1:0]    stage,
  output logic [CW-1:0] count,
  output logic          busy,
  output logic          done,
  output logic [BW-1:0] block_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    HORIZ = 3'd2,
    VERT  = 3'd3,
    ACC   = 3'd4
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] ACC_LAST = CW'(TAIL - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic          done_reg, done_next;
  logic [BW-1:0] blk_reg, blk_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      done_reg  <= 1'b0;
      blk_reg   <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      done_reg  <= done_next;
      blk_reg   <= blk_next;
    end
  end

  // A stalled busy cycle holds everything; done only fires on a real completion.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    done_next  = 1'b0;
    blk_next   = blk_reg;
    if (state_reg == IDLE) begin
      count_next = '0;
      if (start) state_next = LOAD;
    end else if (!stall) begin
      case (state_reg)
        LOAD: begin
          state_next = HORIZ;
          count_next = '0;
        end
        HORIZ: begin
          if (count_reg == CNT_LAST) begin
            state_next = VERT;
            count_next = '0;
          end else begin
            count_next = count_reg + CW'(1);
          end
        end
        VERT: begin
          if (count_reg == CNT_LAST) begin
            state_next = ACC;
            count_next = '0;
          end else begin
            count_next = count_reg + CW'(1);
          end
        end
        ACC: begin
          if (count_reg == ACC_LAST) begin
            state_next = (continuous || start) ? LOAD : IDLE;
            count_next = '0;
            done_next  = 1'b1;
            blk_next   = blk_reg + BW'(1);
          end else begin
            count_next = count_reg + CW'(1);
          end
        end
        default: begin
          state_next = IDLE;
          count_next = '0;
        end
      endcase
    end
  end

  always_comb begin
    stage = 2'd0;
    case (state_reg)
      HORIZ:   stage = 2'd1;
      VERT:    stage = 2'd2;
      ACC:     stage = 2'd3;
      default: stage = 2'd0;
    endcase
  end

  assign busy      = (state_reg != IDLE);
  assign count     = count_reg;
  assign done      = done_reg;
  assign block_cnt = blk_reg;

endmodule

// File: tb/tb_satd_ctrl_gen.sv
// Directed bench for satd_ctrl_gen: default 8x8 instance plus a N=4/TAIL=1/BW=2 instance.
module tb_satd_ctrl_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, stall_a, cont_a;
  logic        start_b, stall_b, cont_b;
  logic [1:0]  stage_a, stage_b;
  logic [2:0]  count_a;
  logic [1:0]  count_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [15:0] blk_a;
  logic [1:0]  blk_b;

  int compared = 0;
  int mismatched = 0;
  int exp_blk_a = 0;
  int exp_blk_b = 0;

  always #5 clk = ~clk;

  satd_ctrl_gen dut_a (
    .clk(clk), .reset(reset), .start(start_a), .stall(stall_a), .continuous(cont_a),
    .stage(stage_a), .count(count_a), .busy(busy_a), .done(done_a), .block_cnt(blk_a)
  );

  satd_ctrl_gen #(.N(4), .TAIL(1), .BW(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .stall(stall_b), .continuous(cont_b),
    .stage(stage_b), .count(count_b), .busy(busy_b), .done(done_b), .block_cnt(blk_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input bit sel, input string tag, input int st, input int cn,
                         input int bz, input int dn);
    if (sel) begin
      chk({tag, ".stage"}, 32'(stage_b), 32'(st));
      chk({tag, ".count"}, 32'(count_b), 32'(cn));
      chk({tag, ".busy"},  32'(busy_b),  32'(bz));
      chk({tag, ".done"},  32'(done_b),  32'(dn));
    end else begin
      chk({tag, ".stage"}, 32'(stage_a), 32'(st));
      chk({tag, ".count"}, 32'(count_a), 32'(cn));
      chk({tag, ".busy"},  32'(busy_a),  32'(bz));
      chk({tag, ".done"},  32'(done_a),  32'(dn));
    end
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) start_b = v; else start_a = v;
  endtask

  task automatic set_stall(input bit sel, input logic v);
    if (sel) stall_b = v; else stall_a = v;
  endtask

  // Entry: just after the start edge (or the chaining edge), LOAD visible.
  // Exit: negedge after the completing edge, done expected high.
  task automatic run_pass(input bit sel, input int n, input int tail, input string tag,
                          input int first_done, input int stall_idx, input int stall_len,
                          input int start_idx, input int exp_blk, input int next_busy);
    int st, cn;
    for (int i = 0; i < 1 + 2 * n + tail; i++) begin
      if (i == 0) begin st = 0; cn = 0; end
      else if (i <= n) begin st = 1; cn = i - 1; end
      else if (i <= 2 * n) begin st = 2; cn = i - 1 - n; end
      else begin st = 3; cn = i - 1 - 2 * n; end
      chk_out(sel, $sformatf("%s[%0d]", tag, i), st, cn, 1, (i == 0) ? first_done : 0);
      set_start(sel, logic'(i == start_idx));
      if (i == stall_idx) begin
        set_stall(sel, 1'b1);
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          chk_out(sel, $sformatf("%s_stall[%0d]", tag, s), st, cn, 1, 0);
        end
        set_stall(sel, 1'b0);
      end
      @(negedge clk);
    end
    set_start(sel, 1'b0);
    chk_out(sel, {tag, "_end"}, 0, 0, next_busy, 1);
    if (sel) chk({tag, "_blk"}, 32'(blk_b), 32'(exp_blk));
    else     chk({tag, "_blk"}, 32'(blk_a), 32'(exp_blk));
    $display("pass %s: block_cnt exp %0d", tag, exp_blk);
  endtask

  task automatic kick(input bit sel);
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    start_a = 0; stall_a = 0; cont_a = 0;
    start_b = 0; stall_b = 0; cont_b = 0;
    repeat (2) @(negedge clk);
    chk_out(0, "rst_a", 0, 0, 0, 0);
    chk("rst_a.blk", 32'(blk_a), 0);
    chk_out(1, "rst_b", 0, 0, 0, 0);
    reset = 1'b0;
    @(negedge clk);
    chk_out(0, "idle_a", 0, 0, 0, 0);

    // basic single pass
    kick(0); exp_blk_a++;
    run_pass(0, 8, 2, "basic", 0, -1, 0, -1, exp_blk_a, 0);
    @(negedge clk);
    chk_out(0, "basic_idle", 0, 0, 0, 0);

    // stall 3 cycles at HORIZ count 4
    kick(0); exp_blk_a++;
    run_pass(0, 8, 2, "stall", 0, 5, 3, -1, exp_blk_a, 0);
    @(negedge clk);
    chk_out(0, "stall_idle", 0, 0, 0, 0);

    // three chained passes
    cont_a = 1'b1;
    kick(0); exp_blk_a++;
    run_pass(0, 8, 2, "chain1", 0, -1, 0, -1, exp_blk_a, 1);
    exp_blk_a++;
    run_pass(0, 8, 2, "chain2", 1, -1, 0, -1, exp_blk_a, 1);
    cont_a = 1'b0;
    exp_blk_a++;
    run_pass(0, 8, 2, "chain3", 1, -1, 0, -1, exp_blk_a, 0);
    @(negedge clk);
    chk_out(0, "chain_idle", 0, 0, 0, 0);

    // start during VERT ignored; stall on the final ACC cycle defers completion
    kick(0); exp_blk_a++;
    run_pass(0, 8, 2, "vstart", 0, 18, 2, 12, exp_blk_a, 0);
    @(negedge clk);
    chk_out(0, "vstart_idle", 0, 0, 0, 0);

    // start on the final ACC cycle chains into LOAD
    kick(0); exp_blk_a++;
    run_pass(0, 8, 2, "astart", 0, -1, 0, 18, exp_blk_a, 1);
    exp_blk_a++;
    run_pass(0, 8, 2, "astart2", 1, -1, 0, -1, exp_blk_a, 0);

    // reset at VERT count 5 with stall high
    kick(0);
    repeat (14) @(negedge clk);
    chk_out(0, "pre_rst", 2, 5, 1, 0);
    stall_a = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    stall_a = 1'b0;
    chk_out(0, "mid_rst", 0, 0, 0, 0);
    chk("mid_rst.blk", 32'(blk_a), 0);
    exp_blk_a = 0;
    kick(0); exp_blk_a++;
    run_pass(0, 8, 2, "post_rst", 0, -1, 0, -1, exp_blk_a, 0);

    // small instance: 10-cycle passes, 2-bit counter wraps after 4
    for (int p = 0; p < 4; p++) begin
      kick(1);
      exp_blk_b = (exp_blk_b + 1) % 4;
      run_pass(1, 4, 1, $sformatf("small%0d", p), 0, -1, 0, -1, exp_blk_b, 0);
      @(negedge clk);
      chk_out(1, $sformatf("small%0d_idle", p), 0, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/satd_ctrl_gen.md
# satd_ctrl_gen

Parametrised sequencer for the SATD datapath, successor to the fixed 8×8 stage/count controller. It drives a stage code and an in-stage counter through load, horizontal transform, vertical transform and accumulate phases. Transform size and accumulate-tail length are set by parameters. It adds a start/busy/done handshake, a stall input, back-to-back continuous operation and a completed-block counter. It sits between the block fetch logic and the transform/accumulate datapath and is the only source of phase timing for them.

## Interface
- N, 8, transform size; rows per transform stage; power of two, 2..64
- CW, $clog2(N), width of count output
- TAIL, 2, accumulate-stage length in cycles; 1..N
- BW, 16, width of block counter
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous reset active-high
- start  in  1  request one pass; sampled only in IDLE or on the final ACC cycle
- stall  in  1  freeze state, count and all outputs except done (see Operation)
- continuous  in  1  when high, chain passes without returning to IDLE
- stage  out  2  0=LOAD/IDLE, 1=HORIZ, 2=VERT, 3=ACC
- count  out  CW  cycle index within current stage
- busy  out  1  high in LOAD, HORIZ, VERT, ACC
- done  out  1  one-cycle pulse after final ACC cycle of each pass
- block_cnt  out  BW  number of completed passes, wraps at 2^BW

## Operation
- States: IDLE, LOAD, HORIZ, VERT, ACC. stage = 0 in IDLE and LOAD; busy distinguishes them.
- IDLE: count = 0. start=1 → LOAD. Otherwise stay.
- LOAD: exactly one cycle, count = 0 → HORIZ.
- HORIZ: count 0..N-1, +1 per cycle; at N-1 → VERT with count = 0.
- VERT: identical to HORIZ; at N-1 → ACC with count = 0.
- ACC: count 0..TAIL-1; at TAIL-1 the pass completes:
  - next state is LOAD if continuous=1 or start=1, else IDLE;
  - count returns to 0, block_cnt increments (wraps to 0 from 2^BW-1), done asserts the following cycle.
- stall=1 in any busy state holds state, count and block_cnt unchanged for that cycle. This includes the final ACC cycle: completion is deferred until a non-stalled cycle. stall is ignored in IDLE.
- start while busy is ignored, except on the final, non-stalled ACC cycle.
- done is high for exactly one cycle per completed pass, never while stalled-in-completion. It may coincide with LOAD in chained mode.
- Count never exceeds N-1 (HORIZ/VERT) or TAIL-1 (ACC); no wrap through illegal values.
- Reset (any cycle, including mid-pass or stalled): state=IDLE, stage=0, count=0, busy=0, done=0, block_cnt=0. Reset has priority over stall and start.

## Timing
- All outputs registered; no combinational input→output path.
- start sampled at edge E0 in IDLE: LOAD after E0, HORIZ count k after E(1+k), VERT count k after E(N+1+k), ACC count k after E(2N+1+k).
- Pass length with no stalls: 1 + 2N + TAIL cycles of busy (19 at defaults). Each stalled cycle adds exactly one.
- done high in the cycle after the final ACC cycle (after E(2N+TAIL+1)).
- Chained passes: no idle gap; LOAD immediately follows final ACC.
- block_cnt updates on the same edge that raises done.

## Test plan
- Reset then start=1 for one cycle, defaults: stage/count sequence 0/0, 1/0..1/7, 2/0..2/7, 3/0..3/1; busy 19 cycles; done one pulse; block_cnt=1; returns to IDLE.
- stall=1 for 3 cycles at HORIZ count 4: count holds 4 for 3 extra cycles; busy 22 cycles total; done timing shifted by 3.
- continuous=1 for 3 passes: no IDLE between passes; done pulses 19 cycles apart, each coinciding with LOAD; block_cnt=3.
- start pulsed during VERT: ignored, one pass only. start=1 on final ACC cycle: next state LOAD.
- reset asserted at VERT count 5, with stall also high: next cycle all outputs at reset values; a new start gives a full 19-cycle pass.
- N=4, TAIL=1, BW=2: pass length 10 cycles; stage 1/2 counts 0..3; after 4 passes block_cnt wraps to 0.
